// File: rtl/axis_stream_pkg.sv
// rtl/axis_stream_pkg.sv - shared types and helpers for the AXI-Stream pattern source
//
// Purpose: FSM state type, default keep-width constants and the final-beat
// TKEEP helper used by axis_pattern_source.
// Ports: none (package).
package axis_stream_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int KEEP_W         = DATA_WIDTH_DEF / 8;
  localparam int BYTE_IDX_W     = (KEEP_W > 1) ? $clog2(KEEP_W) : 1;

  // Widest keep mask the helper can build; callers size-cast to their own width.
  localparam int KEEP_MAX = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    GAP    = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Final-beat byte enables: a zero remainder means the last beat is full.
  function automatic logic [KEEP_MAX-1:0] last_keep(input int unsigned len_mod,
                                                    input int unsigned keep_w = KEEP_W);
    logic [KEEP_MAX-1:0] k;
    int unsigned         n;
    n = (len_mod == 0) ? keep_w : len_mod;
    k = '0;
    for (int unsigned i = 0; i < KEEP_MAX; i++) begin
      if (i < n) k[i] = 1'b1;
    end
    return k;
  endfunction

endpackage

// File: rtl/axis_pattern_source.sv
// rtl/axis_pattern_source.sv - AXI-Stream burst generator with counter payload
//
// Purpose: emits cfg_num_pkts packets of cfg_byte_len bytes each, carrying an
// incrementing data word that starts at cfg_seed and runs across packets, with
// cfg_gap idle cycles between packets. All outputs are registered.
// Ports:
//   ACLK, ARESETN           clock, synchronous active-low reset
//   start                   run request, honoured only in IDLE
//   cfg_byte_len/num_pkts/gap/seed  run configuration, latched on accepted start
//   M_AXIS_TDATA/TKEEP/TLAST/TVALID/TREADY  master stream
//   busy, done, pkt_count   run status
module axis_pattern_source
  import axis_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    cfg_byte_len,
  input  logic [CNT_WIDTH-1:0]    cfg_num_pkts,
  input  logic [GAP_WIDTH-1:0]    cfg_gap,
  input  logic [DATA_WIDTH-1:0]   cfg_seed,
  output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic                    M_AXIS_TLAST,
  output logic                    M_AXIS_TVALID,
  input  logic                    M_AXIS_TREADY,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    pkt_count
);

  localparam int                      KEEP_BYTES   = DATA_WIDTH / 8;
  localparam logic [LEN_WIDTH:0]      KEEP_BYTES_L = (LEN_WIDTH+1)'(KEEP_BYTES);
  localparam logic [KEEP_BYTES-1:0]   KEEP_ALL     = '1;

  state_t                  state;
  logic [LEN_WIDTH-1:0]    beats_m1;     // beats per packet minus one
  logic [LEN_WIDTH-1:0]    beats_left;   // beats still to come after the one on the bus
  logic [KEEP_BYTES-1:0]   keep_last;
  logic [CNT_WIDTH-1:0]    num_pkts;
  logic [GAP_WIDTH-1:0]    gap;
  logic [GAP_WIDTH-1:0]    gap_cnt;

  // Start-time decode of the packet geometry. One extra bit keeps the
  // round-up addition from overflowing for the largest byte length.
  logic [LEN_WIDTH:0]      len_ext;
  logic [LEN_WIDTH:0]      cfg_beats;
  logic [LEN_WIDTH:0]      cfg_rem;
  logic [KEEP_BYTES-1:0]   cfg_keep;
  logic                    cfg_one_beat;

  always_comb begin
    len_ext      = {1'b0, cfg_byte_len};
    cfg_beats    = (len_ext + KEEP_BYTES_L - 1'b1) / KEEP_BYTES_L;
    cfg_rem      = len_ext % KEEP_BYTES_L;
    cfg_keep     = KEEP_BYTES'(last_keep(32'(cfg_rem), KEEP_BYTES));
    cfg_one_beat = (cfg_beats == (LEN_WIDTH+1)'(1));
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state         <= IDLE;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TKEEP  <= '0;
      M_AXIS_TLAST  <= 1'b0;
      M_AXIS_TVALID <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pkt_count     <= '0;
      beats_m1      <= '0;
      beats_left    <= '0;
      keep_last     <= '0;
      num_pkts      <= '0;
      gap           <= '0;
      gap_cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            num_pkts  <= cfg_num_pkts;
            gap       <= cfg_gap;
            keep_last <= cfg_keep;
            beats_m1  <= LEN_WIDTH'(cfg_beats - 1'b1);
            pkt_count <= '0;
            if (cfg_byte_len == '0 || cfg_num_pkts == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state         <= SEND;
              busy          <= 1'b1;
              M_AXIS_TVALID <= 1'b1;
              M_AXIS_TDATA  <= cfg_seed;
              beats_left    <= LEN_WIDTH'(cfg_beats - 1'b1);
              M_AXIS_TLAST  <= cfg_one_beat;
              M_AXIS_TKEEP  <= cfg_one_beat ? cfg_keep : KEEP_ALL;
            end
          end
        end

        SEND: begin
          // TVALID is always high here, so TREADY alone marks a handshake.
          if (M_AXIS_TREADY) begin
            M_AXIS_TDATA <= M_AXIS_TDATA + 1'b1;
            if (M_AXIS_TLAST) begin
              pkt_count <= pkt_count + 1'b1;
              // Preload the next packet's first beat; only TVALID depends
              // on whether it goes out now, after a gap, or never.
              beats_left   <= beats_m1;
              M_AXIS_TLAST <= (beats_m1 == '0);
              M_AXIS_TKEEP <= (beats_m1 == '0) ? keep_last : KEEP_ALL;
              if (pkt_count + 1'b1 == num_pkts) begin
                state         <= FINISH;
                M_AXIS_TVALID <= 1'b0;
                M_AXIS_TLAST  <= 1'b0;
                busy          <= 1'b0;
                done          <= 1'b1;
              end else if (gap != '0) begin
                state         <= GAP;
                M_AXIS_TVALID <= 1'b0;
                gap_cnt       <= gap;
              end
            end else begin
              beats_left   <= beats_left - 1'b1;
              M_AXIS_TLAST <= (beats_left == LEN_WIDTH'(1));
              M_AXIS_TKEEP <= (beats_left == LEN_WIDTH'(1)) ? keep_last : KEEP_ALL;
            end
          end
        end

        GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt == GAP_WIDTH'(1)) begin
            state         <= SEND;
            M_AXIS_TVALID <= 1'b1;
          end
        end

        FINISH: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
